// File: rtl/demux_driver.sv
// demux_driver: upstream driver for a 1-to-8 demultiplexer.
// Requests {req_sel, req_d} are queued in a small FIFO, then each one is presented on
// SEL/D for HOLD cycles, followed by one return-to-zero GAP cycle so the demux outputs
// are all-zero between consecutive items.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   req_valid  - request present
//   req_ready  - FIFO can accept a request (registered state only)
//   req_sel    - target channel 0..7
//   req_d      - data bit to route
//   SEL        - registered demux select
//   D          - registered demux data
//   busy       - FSM not idle or FIFO non-empty
//   done       - one-cycle pulse during the GAP cycle of each item
//   sent_cnt   - wrapping count of completed items
module demux_driver #(
  parameter int unsigned HOLD  = 4,  // 1..255
  parameter int unsigned DEPTH = 4   // power of two, >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_sel,
  input  logic       req_d,
  output logic [2:0] SEL,
  output logic       D,
  output logic       busy,
  output logic       done,
  output logic [7:0] sent_cnt
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = $clog2(DEPTH) + 1;
  localparam logic [7:0]  HoldInit = 8'(HOLD - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

  state_e          state_q, state_d;
  logic [3:0]      mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [2:0]      sel_q, sel_d;
  logic            d_q, d_d;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      sent_q, sent_d;
  logic            full, empty, push, pop;

  // FIFO control: full refuses a push even if a pop happens in the same cycle, and pop
  // only looks at registered occupancy, so a fresh entry is never popped on its push edge.
  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state_q == StIdle) && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {req_sel, req_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      d_q     <= 1'b0;
      hold_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      d_q     <= d_d;
      hold_q  <= hold_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    d_d     = d_q;
    hold_d  = hold_q;
    sent_d  = sent_q;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        d_d = 1'b0;
        if (!empty) begin
          {sel_d, d_d} = mem[rd_ptr_q];
          hold_d       = HoldInit;
          state_d      = StDrive;
        end
      end
      StDrive: begin
        if (hold_q == 8'd0) begin
          d_d     = 1'b0;
          state_d = StGap;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      StGap: begin
        done    = 1'b1;
        d_d     = 1'b0;
        sent_d  = sent_q + 8'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign SEL      = sel_q;
  assign D        = d_q;
  assign sent_cnt = sent_q;
  assign busy     = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_demux_driver.sv
// Directed testbench for demux_driver (HOLD=4, DEPTH=4).
module tb_demux_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_sel;
  logic       req_d;
  logic [2:0] SEL;
  logic       D;
  logic       busy;
  logic       done;
  logic [7:0] sent_cnt;

  int checks = 0;
  int errors = 0;

  demux_driver #(.HOLD(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_d     (req_d),
    .SEL       (SEL),
    .D         (D),
    .busy      (busy),
    .done      (done),
    .sent_cnt  (sent_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counter and a mid-cycle monitor of D rising edges and done pulses.
  int         cyc = 0;
  int         rise_cyc[$];
  logic [2:0] rise_sel[$];
  int         done_cnt = 0;
  logic       d_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (D && !d_prev) begin
      rise_cyc.push_back(cyc);
      rise_sel.push_back(SEL);
    end
    if (done) done_cnt = done_cnt + 1;
    d_prev = D;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    rise_cyc.delete();
    rise_sel.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int bad;
    req_valid = 1'b0;
    req_sel   = 3'd0;
    req_d     = 1'b0;
    rst_n     = 1'b0;
    #3;
    checks++;
    if ({SEL, D, done, sent_cnt, req_ready, busy} !== {3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got SEL=%0d D=%b done=%b cnt=%0d ready=%b busy=%b, want 0 0 0 0 1 0",
               SEL, D, done, sent_cnt, req_ready, busy);
    end
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({SEL, D, done, sent_cnt, req_ready, busy} !== {3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0})
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_idle: %0d cycles deviated from reset values, want 0", bad);
    end
  endtask

  task automatic test_single();
    logic [7:0] y;
    clear_monitor();
    req_valid = 1'b1;
    req_sel   = 3'd5;
    req_d     = 1'b1;
    step();  // push edge t0
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || D !== 1'b0) begin
      errors++;
      $display("FAIL single_queued: got busy=%b D=%b, want busy=1 D=0", busy, D);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      y = 8'(D) << SEL;
      checks++;
      if (SEL !== 3'd5 || D !== 1'b1 || y !== 8'b0010_0000 || done !== 1'b0) begin
        errors++;
        $display("FAIL single_drive[%0d]: got SEL=%0d D=%b Y=%b done=%b, want 5 1 00100000 0",
                 i, SEL, D, y, done);
      end
    end
    step();
    checks++;
    if (SEL !== 3'd5 || D !== 1'b0 || done !== 1'b1 || sent_cnt !== 8'd0) begin
      errors++;
      $display("FAIL single_gap: got SEL=%0d D=%b done=%b cnt=%0d, want 5 0 1 0",
               SEL, D, done, sent_cnt);
    end
    step();
    checks++;
    if (done !== 1'b0 || sent_cnt !== 8'd1 || busy !== 1'b0 || D !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got done=%b cnt=%0d busy=%b D=%b, want 0 1 0 0",
               done, sent_cnt, busy, D);
    end
  endtask

  task automatic test_fill();
    int   n;
    int   guard;
    int   not_ready;
    logic rdy;
    clear_monitor();
    n = 0;
    not_ready = 0;
    req_d = 1'b1;
    while (n < 8 && guard < 200) begin
      req_valid = 1'b1;
      req_sel   = 3'(n);
      rdy       = req_ready;
      if (!rdy) not_ready++;
      step();
      if (rdy) n++;
      guard++;
    end
    req_valid = 1'b0;
    guard = 0;
    while (busy && guard < 200) begin
      step();
      guard++;
    end
    checks++;
    if (n !== 8 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_complete: got pushed=%0d busy=%b, want 8 0", n, busy);
    end
    checks++;
    if (not_ready == 0) begin
      errors++;
      $display("FAIL fill_ready_low: req_ready low for %0d cycles, want >0", not_ready);
    end
    checks++;
    if (rise_sel.size() !== 8) begin
      errors++;
      $display("FAIL fill_items: got %0d D rising edges, want 8", rise_sel.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rise_sel[i] !== 3'(i)) begin
          errors++;
          $display("FAIL fill_order[%0d]: got SEL=%0d, want %0d", i, rise_sel[i], i);
        end
        if (i > 0) begin
          checks++;
          if (rise_cyc[i] - rise_cyc[i-1] !== 6) begin
            errors++;
            $display("FAIL fill_spacing[%0d]: got %0d cycles, want 6", i,
                     rise_cyc[i] - rise_cyc[i-1]);
          end
        end
      end
    end
    checks++;
    if (sent_cnt !== 8'd9 || done_cnt !== 8) begin
      errors++;
      $display("FAIL fill_count: got cnt=%0d dones=%0d, want 9 8", sent_cnt, done_cnt);
    end
  endtask

  task automatic test_zero_data();
    int bad;
    clear_monitor();
    req_valid = 1'b1;
    req_sel   = 3'd3;
    req_d     = 1'b0;
    step();
    req_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (SEL !== 3'd3 || D !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL zero_hold: %0d cycles with SEL!=3 or D!=0, want 0", bad);
    end
    step();
    checks++;
    if (done_cnt !== 1 || sent_cnt !== 8'd10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got dones=%0d cnt=%0d busy=%b, want 1 10 0",
               done_cnt, sent_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    clear_monitor();
    req_d     = 1'b1;
    req_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req_sel = 3'(i);
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (D !== 1'b1 || SEL !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_drive: got D=%b SEL=%0d busy=%b, want 1 1 1", D, SEL, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (D !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || sent_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_async: got D=%b ready=%b busy=%b cnt=%0d, want 0 1 0 0",
               D, req_ready, busy, sent_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_monitor();
    repeat (40) step();
    checks++;
    if (rise_sel.size() !== 0 || done_cnt !== 0 || sent_cnt !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_discard: got rises=%0d dones=%0d cnt=%0d busy=%b, want 0 0 0 0",
               rise_sel.size(), done_cnt, sent_cnt, busy);
    end
  endtask

  task automatic test_wrap();
    int   pushed;
    int   seen;
    int   guard;
    logic was_done;
    logic rdy;
    do_reset();
    clear_monitor();
    pushed   = 0;
    seen     = 0;
    guard    = 0;
    was_done = 1'b0;
    req_d    = 1'b1;
    while (seen < 256 && guard < 2000) begin
      req_valid = (pushed < 256);
      req_sel   = 3'(pushed);
      rdy       = req_ready;
      step();
      if (rdy && req_valid) pushed++;
      // sent_cnt reflects an item on the cycle after its GAP
      if (was_done) begin
        seen++;
        if (seen == 255) begin
          checks++;
          if (sent_cnt !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: got cnt=%0d, want 255", sent_cnt);
          end
        end
        if (seen == 256) begin
          checks++;
          if (sent_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_256: got cnt=%0d, want 0", sent_cnt);
          end
        end
      end
      was_done = done;
      guard++;
    end
    req_valid = 1'b0;
    repeat (10) step();
    checks++;
    if (seen !== 256 || done_cnt !== 256 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_dones: got seen=%0d dones=%0d busy=%b, want 256 256 0",
               seen, done_cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_zero_data();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
